// File: rtl/ins_align_pkg.sv
// Shared constants and helpers for the fetch-to-decode instruction alignment queue.
package ins_align_pkg;

    localparam logic [1:0]  C_OPCODE_FULL      = 2'b11;
    localparam logic [31:0] C_DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        POP_NONE = 2'd0,
        POP_ONE  = 2'd1,
        POP_TWO  = 2'd2
    } pop_e;

    function automatic logic is_compressed(input logic [15:0] hw);
        return hw[1:0] != C_OPCODE_FULL;
    endfunction

    // Round a pc down to the start of the fetch packet that contains it.
    function automatic logic [31:0] align_fetch_pc(input logic [31:0] pc, input int unsigned fetch_hw);
        logic [31:0] mask;
        mask = 32'(2 * fetch_hw) - 32'd1;
        return pc & ~mask;
    endfunction

endpackage

// File: rtl/hw_ring_buffer.sv
// Circular halfword buffer: packet-wide push at a halfword offset, pop of one or two halfwords.
module hw_ring_buffer
    import ins_align_pkg::*;
#(
    parameter int FETCH_HW = 2,
    parameter int HW_DEPTH = 8,
    localparam int OFF_W   = $clog2(FETCH_HW),
    localparam int CNT_W   = $clog2(HW_DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    push_en,
    input  logic [OFF_W-1:0]        push_skip,
    input  logic [16*FETCH_HW-1:0]  push_data,
    input  pop_e                    pop,
    output logic [15:0]             hw0,
    output logic [15:0]             hw1,
    output logic [CNT_W-1:0]        count
);

    localparam int PTR_W = $clog2(HW_DEPTH);

    logic [15:0]      ring [HW_DEPTH];
    logic [PTR_W-1:0] head;
    logic [CNT_W-1:0] cnt;
    logic [PTR_W-1:0] wr_idx [FETCH_HW];
    logic [FETCH_HW-1:0] wr_en;
    logic [CNT_W-1:0] push_amt;
    logic [CNT_W-1:0] pop_amt;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        wr_en    = '0;
        push_amt = '0;
        pop_amt  = '0;
        for (int i = 0; i < FETCH_HW; i++) begin
            wr_en[i]  = push_en && (OFF_W'(i) >= push_skip);
            wr_idx[i] = head + cnt[PTR_W-1:0] + PTR_W'(i) - PTR_W'(push_skip);
        end
        if (push_en) begin
            push_amt = CNT_W'(FETCH_HW) - CNT_W'(push_skip);
        end
        case (pop)
            POP_ONE: pop_amt = CNT_W'(1);
            POP_TWO: pop_amt = CNT_W'(2);
            default: pop_amt = '0;
        endcase
    end

    // NOTE: the storage array is reset as well, so hw0/ins_l1 read a defined zero straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            cnt  <= '0;
            for (int i = 0; i < HW_DEPTH; i++) begin
                ring[i] <= 16'h0000;
            end
        end else if (flush) begin
            cnt <= '0;
        end else begin
            for (int i = 0; i < FETCH_HW; i++) begin
                if (wr_en[i]) begin
                    ring[wr_idx[i]] <= push_data[16*i +: 16];
                end
            end
            head <= head + PTR_W'(pop_amt);
            cnt  <= cnt + push_amt - pop_amt;
        end
    end

    assign hw0   = ring[head];
    assign hw1   = ring[head + PTR_W'(1)];
    assign count = cnt;

endmodule

// File: rtl/ins_align_queue.sv
// Instruction alignment queue: buffers fetch packets and emits one 16- or 32-bit instruction per handshake.
module ins_align_queue
    import ins_align_pkg::*;
#(
    parameter int          FETCH_HW = 2,
    parameter int          HW_DEPTH = 8,
    parameter logic [31:0] RESET_PC = C_DEFAULT_RESET_PC
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fetch_valid_l0,
    output logic                    fetch_ready_l0,
    input  logic [16*FETCH_HW-1:0]  fetch_data_l0,
    input  logic [31:0]             fetch_pc_l0,
    input  logic                    redirect_en,
    input  logic [31:0]             redirect_addr,
    output logic                    ins_valid_l1,
    input  logic                    ins_ready_l1,
    output logic [31:0]             ins_l1,
    output logic [31:0]             pc_l1,
    output logic                    ins_c_l1
);

    localparam int OFF_W = $clog2(FETCH_HW);
    localparam int CNT_W = $clog2(HW_DEPTH) + 1;

    logic [CNT_W-1:0] count;
    logic [15:0]      hw0;
    logic [15:0]      hw1;
    logic [31:0]      head_pc;
    logic [31:0]      exp_fetch_pc;
    logic [OFF_W-1:0] skip;
    logic             hw0_c;
    logic             push_ok;
    pop_e             pop_sel;

    hw_ring_buffer #(
        .FETCH_HW (FETCH_HW),
        .HW_DEPTH (HW_DEPTH)
    ) u_ring (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_en),
        .push_en   (push_ok),
        .push_skip (skip),
        .push_data (fetch_data_l0),
        .pop       (pop_sel),
        .hw0       (hw0),
        .hw1       (hw1),
        .count     (count)
    );

    assign fetch_ready_l0 = (CNT_W'(HW_DEPTH) - count) >= CNT_W'(FETCH_HW);

    // Packets not at the expected address are stale (pre-redirect) and are accepted but dropped.
    assign push_ok = fetch_valid_l0 && fetch_ready_l0 && !redirect_en
                  && (fetch_pc_l0 == exp_fetch_pc);

    assign hw0_c        = is_compressed(hw0);
    assign ins_valid_l1 = !redirect_en
                       && ((count >= CNT_W'(2)) || ((count == CNT_W'(1)) && hw0_c));
    // Held low while the buffer is empty so the idle/reset value is a clean zero.
    assign ins_c_l1     = hw0_c && (count != '0);
    assign ins_l1       = hw0_c ? {16'h0000, hw0} : {hw1, hw0};
    assign pc_l1        = head_pc;

    always_comb begin
        pop_sel = POP_NONE;
        if (ins_valid_l1 && ins_ready_l1) begin
            pop_sel = hw0_c ? POP_ONE : POP_TWO;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_pc      <= {RESET_PC[31:1], 1'b0};
            exp_fetch_pc <= align_fetch_pc(RESET_PC, FETCH_HW);
            skip         <= RESET_PC[OFF_W:1];
        end else if (redirect_en) begin
            head_pc      <= {redirect_addr[31:1], 1'b0};
            exp_fetch_pc <= align_fetch_pc(redirect_addr, FETCH_HW);
            skip         <= redirect_addr[OFF_W:1];
        end else begin
            if (push_ok) begin
                skip         <= '0;
                exp_fetch_pc <= exp_fetch_pc + 32'(2 * FETCH_HW);
            end
            case (pop_sel)
                POP_ONE: head_pc <= head_pc + 32'd2;
                POP_TWO: head_pc <= head_pc + 32'd4;
                default: head_pc <= head_pc;
            endcase
        end
    end

endmodule

// File: tb/tb_ins_align_queue.sv
// Scoreboard bench for ins_align_queue: a halfword-stream reference model predicts every instruction.
module tb_ins_align_queue;

    localparam int FETCH_HW = 2;
    localparam int HW_DEPTH = 8;

    logic        clk;
    logic        rst;
    logic        fetch_valid_l0;
    logic        fetch_ready_l0;
    logic [31:0] fetch_data_l0;
    logic [31:0] fetch_pc_l0;
    logic        redirect_en;
    logic [31:0] redirect_addr;
    logic        ins_valid_l1;
    logic        ins_ready_l1;
    logic [31:0] ins_l1;
    logic [31:0] pc_l1;
    logic        ins_c_l1;

    ins_align_queue #(
        .FETCH_HW (FETCH_HW),
        .HW_DEPTH (HW_DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_valid_l0 (fetch_valid_l0),
        .fetch_ready_l0 (fetch_ready_l0),
        .fetch_data_l0  (fetch_data_l0),
        .fetch_pc_l0    (fetch_pc_l0),
        .redirect_en    (redirect_en),
        .redirect_addr  (redirect_addr),
        .ins_valid_l1   (ins_valid_l1),
        .ins_ready_l1   (ins_ready_l1),
        .ins_l1         (ins_l1),
        .pc_l1          (pc_l1),
        .ins_c_l1       (ins_c_l1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        logic        c;
    } exp_t;

    // Reference model: complete instructions waiting for decode, plus trailing loose halfwords.
    exp_t        exp_q[$];
    logic [15:0] part_q[$];
    logic [31:0] part_pc;
    logic [31:0] m_exp_pc;
    int          m_skip;

    int checks;
    int failures;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int model_count();
        int n = part_q.size();
        foreach (exp_q[i]) n += exp_q[i].c ? 1 : 2;
        return n;
    endfunction

    function automatic void model_extract();
        logic [15:0] hw;
        exp_t e;
        while (part_q.size() > 0) begin
            hw = part_q[0];
            if (hw[1:0] != 2'b11) begin
                e.ins = {16'h0000, hw}; e.pc = part_pc; e.c = 1'b1;
                exp_q.push_back(e);
                void'(part_q.pop_front());
                part_pc += 2;
            end else if (part_q.size() >= 2) begin
                e.ins = {part_q[1], hw}; e.pc = part_pc; e.c = 1'b0;
                exp_q.push_back(e);
                void'(part_q.pop_front());
                void'(part_q.pop_front());
                part_pc += 4;
            end else begin
                break;
            end
        end
    endfunction

    function automatic void model_push(input logic [31:0] pc, input logic [31:0] d);
        if (pc != m_exp_pc) return;
        for (int i = m_skip; i < FETCH_HW; i++) part_q.push_back(d[16*i +: 16]);
        m_skip = 0;
        m_exp_pc += 4;
        model_extract();
    endfunction

    function automatic void model_redirect(input logic [31:0] a);
        exp_q.delete();
        part_q.delete();
        part_pc  = a & ~32'd1;
        m_exp_pc = a & ~32'd3;
        m_skip   = (a >> 1) & 1;
    endfunction

    // One bench cycle: inputs driven just after a rising edge, model updated after the edge that consumes them.
    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] d,
                         input logic redir, input logic [31:0] ra);
        logic exp_rdy;
        exp_rdy = model_count() <= HW_DEPTH - FETCH_HW;
        check_eq("fetch_ready", fetch_ready_l0, exp_rdy);
        fetch_valid_l0 = v;
        fetch_pc_l0    = pc;
        fetch_data_l0  = d;
        redirect_en    = redir;
        redirect_addr  = ra;
        @(posedge clk); #1;
        fetch_valid_l0 = 1'b0;
        redirect_en    = 1'b0;
        if (redir) model_redirect(ra);
        else if (v && exp_rdy) model_push(pc, d);
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] d);
        drive(1'b1, pc, d, 1'b0, 32'h0);
    endtask

    task automatic redirect(input logic [31:0] a);
        drive(1'b0, 32'h0, 32'h0, 1'b1, a);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic drain(input int max);
        int n = 0;
        ins_ready_l1 = 1'b1;
        while (exp_q.size() > 0 && n < max) begin
            idle(1);
            n++;
        end
        check_eq("drain_timeout", exp_q.size(), 0);
    endtask

    function automatic logic [15:0] rand_hw();
        logic [15:0] hw = 16'($urandom);
        if ($urandom_range(0, 1) == 1) hw[1:0] = 2'b11;
        return hw;
    endfunction

    // Monitor: checks the presented instruction every cycle and retires it on a handshake.
    initial begin
        logic exp_v;
        forever begin
            @(negedge clk);
            exp_v = (exp_q.size() > 0) && !redirect_en && !rst;
            check_eq("ins_valid", ins_valid_l1, exp_v);
            if (!redirect_en) begin
                check_eq("pc_l1", pc_l1, (exp_q.size() > 0) ? exp_q[0].pc : part_pc);
            end
            if (exp_v && ins_valid_l1) begin
                check_eq("ins_l1", ins_l1, exp_q[0].ins);
                check_eq("ins_c_l1", ins_c_l1, exp_q[0].c);
                if (ins_ready_l1) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        checks         = 0;
        failures       = 0;
        rst            = 1'b1;
        fetch_valid_l0 = 1'b0;
        fetch_pc_l0    = 32'h0;
        fetch_data_l0  = 32'h0;
        redirect_en    = 1'b0;
        redirect_addr  = 32'h0;
        ins_ready_l1   = 1'b1;
        model_redirect(32'h0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_fetch_ready", fetch_ready_l0, 1'b1);
        check_eq("rst_ins_valid", ins_valid_l1, 1'b0);
        check_eq("rst_ins_l1", ins_l1, 32'h0);
        check_eq("rst_pc_l1", pc_l1, 32'h0);
        check_eq("rst_ins_c", ins_c_l1, 1'b0);
        rst = 1'b0;

        // 1: single standard instruction, visible the cycle after acceptance
        push(32'h0, 32'h00A0_0093);
        check_eq("t1_valid", ins_valid_l1, 1'b1);
        check_eq("t1_ins", ins_l1, 32'h00A0_0093);
        check_eq("t1_c", ins_c_l1, 1'b0);
        drain(20);

        // 2: two compressed instructions in one packet
        redirect(32'h0);
        push(32'h0, 32'h4505_4501);
        drain(20);

        // 3: standard instruction straddling two packets
        redirect(32'h0);
        push(32'h0, 32'h0093_4501);
        idle(3);
        check_eq("t3_straddle_wait", ins_valid_l1, 1'b0);
        push(32'h4, 32'h4505_00A0);
        drain(20);

        // 4: halfword-aligned redirect drops the low halfword
        redirect(32'h102);
        push(32'h100, 32'h4501_4505);
        check_eq("t4_ins", ins_l1, 32'h0000_4501);
        check_eq("t4_pc", pc_l1, 32'h102);
        check_eq("t4_c", ins_c_l1, 1'b1);
        drain(20);

        // 5: stale packet after redirect is consumed and dropped
        redirect(32'h200);
        push(32'h00C, 32'h00A0_0093);
        check_eq("t5_stale_valid", ins_valid_l1, 1'b0);
        push(32'h200, 32'h00A0_0093);
        check_eq("t5_ins", ins_l1, 32'h00A0_0093);
        check_eq("t5_pc", pc_l1, 32'h200);
        drain(20);

        // 6: fill to capacity under backpressure, then release
        redirect(32'h0);
        ins_ready_l1 = 1'b0;
        for (int i = 0; i < 4; i++) push(32'(4 * i), 32'h00A0_0093);
        check_eq("t6_full_ready", fetch_ready_l0, 1'b0);
        check_eq("t6_hold_ins", ins_l1, 32'h00A0_0093);
        check_eq("t6_hold_pc", pc_l1, 32'h0);
        idle(3);
        drain(40);

        // 7: asynchronous reset with five halfwords buffered
        redirect(32'h0);
        ins_ready_l1 = 1'b0;
        push(32'h0, 32'h4505_4501);
        push(32'h4, 32'h0093_4501);
        push(32'h8, 32'h4505_00A0);
        ins_ready_l1 = 1'b1;
        idle(1);
        ins_ready_l1 = 1'b0;
        check_eq("t7_model_count", model_count(), 5);
        rst = 1'b1;
        model_redirect(32'h0);
        #2;
        check_eq("t7_ins_valid", ins_valid_l1, 1'b0);
        check_eq("t7_pc", pc_l1, 32'h0);
        check_eq("t7_ready", fetch_ready_l0, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        ins_ready_l1 = 1'b1;

        // Randomized traffic: sequential packets, stale packets, redirects and backpressure
        for (int n = 0; n < 1500; n++) begin
            int r;
            ins_ready_l1 = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 99);
            if (r < 3) redirect(32'($urandom_range(0, 32'h3FF)) & ~32'd1);
            else if (r < 8) push(m_exp_pc ^ 32'h10, {rand_hw(), rand_hw()});
            else if (r < 70) push(m_exp_pc, {rand_hw(), rand_hw()});
            else idle(1);
        end
        drain(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
